// File: rtl/ha_add_sequencer_if.sv
// Operand/result handshake bundle for ha_add_sequencer.
// The master modport is the producer/consumer side; the slave modport is the sequencer.
interface ha_add_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] sum_out;
  logic             carry_out;
  logic [CNT_W-1:0] iter_count;
  logic             busy;

  modport master (
    output start_valid, a_in, b_in, res_ready,
    input  start_ready, res_valid, sum_out, carry_out, iter_count, busy
  );

  modport slave (
    input  start_valid, a_in, b_in, res_ready,
    output start_ready, res_valid, sum_out, carry_out, iter_count, busy
  );
endinterface

// File: rtl/ha_add_sequencer.sv
// Multi-cycle adder that iterates a bitwise half adder, feeding the shifted carry vector
// back until no carry remains, with valid/ready handshakes on both sides.
module HalfAdder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic [WIDTH-1:0] carry_o
);
  assign sum_o   = a_i ^ b_i;
  assign carry_o = a_i & b_i;
endmodule

module ha_add_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic                clk,
  input logic                rst,
  ha_add_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             cacc_q, cacc_d;
  logic [CNT_W-1:0] iters_q, iters_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [WIDTH-1:0] haSum;
  logic [WIDTH-1:0] haCarry;

  HalfAdder #(.WIDTH(WIDTH)) u_half_adder (
    .a_i     (x_q),
    .b_i     (y_q),
    .sum_o   (haSum),
    .carry_o (haCarry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      cacc_q  <= 1'b0;
      iters_q <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cacc_q  <= cacc_d;
      iters_q <= iters_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cacc_d  = cacc_q;
    iters_d = iters_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    count_d = count_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start_valid) begin
          x_d     = bus.a_in;
          y_d     = bus.b_in;
          cacc_d  = 1'b0;
          iters_d = '0;
          state_d = ITER;
        end
      end
      ITER: begin
        if (haCarry == '0) begin
          sum_d   = haSum;
          carry_d = cacc_q;
          count_d = iters_q + CNT_W'(1);
          state_d = DONE;
        end else begin
          // A carry leaving the top bit is the addition's carry-out; at most one ever does.
          x_d     = haSum;
          y_d     = {haCarry[WIDTH-2:0], 1'b0};
          cacc_d  = cacc_q | haCarry[WIDTH-1];
          iters_d = iters_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.start_ready = (state_q == IDLE);
  assign bus.res_valid   = (state_q == DONE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.sum_out     = sum_q;
  assign bus.carry_out   = carry_q;
  assign bus.iter_count  = count_q;
endmodule

// File: tb/tb_ha_add_sequencer.sv
// Directed self-checking bench for ha_add_sequencer with hand-computed sums,
// carries, evaluation counts and latencies.
module tb_ha_add_sequencer;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  ha_add_sequencer_if #(.WIDTH(32), .CNT_W(6)) bus ();

  ha_add_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Called just after a negedge: launches one add, waits for the result and checks it.
  task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] eSum, input logic eCarry, input int eCount);
    int lat;
    checkOutput({tag, ":start_ready"}, 64'(bus.start_ready), 64'd1);
    bus.start_valid = 1'b1;
    bus.a_in        = a;
    bus.b_in        = b;
    @(posedge clk);
    @(negedge clk);
    bus.start_valid = 1'b0;
    checkOutput({tag, ":busy"}, 64'(bus.busy), 64'd1);
    lat = 0;
    while (!bus.res_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, ":res_valid"}, 64'(bus.res_valid), 64'd1);
    checkOutput({tag, ":latency"}, 64'(lat), 64'(eCount));
    checkOutput({tag, ":sum"}, 64'(bus.sum_out), 64'(eSum));
    checkOutput({tag, ":carry"}, 64'(bus.carry_out), 64'(eCarry));
    checkOutput({tag, ":iters"}, 64'(bus.iter_count), 64'(eCount));
    checkOutput({tag, ":ready_in_done"}, 64'(bus.start_ready), 64'd0);
  endtask

  task automatic acceptResult(input string tag, input logic [31:0] eSum);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    checkOutput({tag, ":ready_after_hs"}, 64'(bus.start_ready), 64'd1);
    checkOutput({tag, ":valid_after_hs"}, 64'(bus.res_valid), 64'd0);
    checkOutput({tag, ":sum_held"}, 64'(bus.sum_out), 64'(eSum));
  endtask

  initial begin
    bit sawValid;
    total           = 0;
    bad             = 0;
    rst             = 1'b1;
    bus.start_valid = 1'b0;
    bus.res_ready   = 1'b0;
    bus.a_in        = '0;
    bus.b_in        = '0;

    repeat (2) @(negedge clk);
    checkOutput("rst:start_ready", 64'(bus.start_ready), 64'd1);
    checkOutput("rst:res_valid", 64'(bus.res_valid), 64'd0);
    checkOutput("rst:busy", 64'(bus.busy), 64'd0);
    checkOutput("rst:sum", 64'(bus.sum_out), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus("5+0", 32'd5, 32'd0, 32'd5, 1'b0, 1);
    acceptResult("5+0", 32'd5);
    applyStimulus("F+1", 32'h0000000F, 32'h00000001, 32'h00000010, 1'b0, 5);
    acceptResult("F+1", 32'h00000010);
    applyStimulus("1+max", 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 33);
    acceptResult("1+max", 32'h00000000);
    applyStimulus("max+max", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 2);
    acceptResult("max+max", 32'hFFFFFFFE);

    // Reset in the middle of the long ripple; no result may surface afterwards.
    bus.start_valid = 1'b1;
    bus.a_in        = 32'h00000001;
    bus.b_in        = 32'hFFFFFFFF;
    @(posedge clk);
    @(negedge clk);
    bus.start_valid = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("midrst:busy_before", 64'(bus.busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst:start_ready", 64'(bus.start_ready), 64'd1);
    checkOutput("midrst:res_valid", 64'(bus.res_valid), 64'd0);
    checkOutput("midrst:busy", 64'(bus.busy), 64'd0);
    checkOutput("midrst:sum", 64'(bus.sum_out), 64'd0);
    checkOutput("midrst:carry", 64'(bus.carry_out), 64'd0);
    checkOutput("midrst:iters", 64'(bus.iter_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    sawValid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.res_valid) sawValid = 1'b1;
    end
    checkOutput("midrst:no_result", 64'(sawValid), 64'd0);
    checkOutput("midrst:idle_after", 64'(bus.start_ready), 64'd1);

    applyStimulus("3+4", 32'd3, 32'd4, 32'd7, 1'b0, 1);
    for (int i = 0; i < 10; i++) begin
      bus.start_valid = ~bus.start_valid;
      bus.a_in        = $urandom;
      bus.b_in        = $urandom;
      @(negedge clk);
      checkOutput("bp:sum", 64'(bus.sum_out), 64'd7);
      checkOutput("bp:start_ready", 64'(bus.start_ready), 64'd0);
      checkOutput("bp:res_valid", 64'(bus.res_valid), 64'd1);
    end
    bus.start_valid = 1'b0;
    acceptResult("3+4", 32'd7);
    applyStimulus("msb+msb", 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 2);
    acceptResult("msb+msb", 32'h00000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
